// File: rtl/replay_retire_q.sv
// rtl/replay_retire_q.sv - retire queue behind the replay pipeline: unrefusable input, FIFO plus output register, registered stall
// Back-pressure is sized so SKID in-flight beats still fit after stall_r asserts.
module replay_retire_q #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int SKID  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 in,
  input  logic                         in_vld,
  output logic [W-1:0]                 out_r,
  output logic                         out_vld_r,
  input  logic                         out_accept,
  output logic                         stall_r,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy_r,
  output logic                         overflow_r
);

  localparam int CW = $clog2(DEPTH+2);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH+1);
  localparam logic [CW-1:0] THRESH   = CW'(DEPTH+1-SKID);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic pop, drop, push, bypass, fifo_wr, fifo_rd, fifo_empty;
  logic [AW:0] fifo_cnt;
  logic        wrap_ok;

  always_comb begin
    pop        = out_vld_q & out_accept;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    // A beat arriving at full capacity with no pop has nowhere to go.
    drop       = in_vld & (occ_q == FULL_OCC) & ~pop;
    push       = in_vld & ~drop;
    bypass     = push & fifo_empty & (~out_vld_q | pop);
    fifo_wr    = push & ~bypass;
    fifo_rd    = (pop | ~out_vld_q) & ~fifo_empty;

    out_d     = out_q;
    out_vld_d = out_vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (fifo_rd) begin
      out_d     = mem_q[rd_ptr_q[AW-1:0]];
      out_vld_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      out_d     = in;
      out_vld_d = 1'b1;
    end else if (pop) begin
      out_vld_d = 1'b0;
    end

    if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;

    occ_d   = occ_q + CW'(push) - CW'(pop);
    stall_d = (occ_d >= THRESH);
    ovf_d   = ovf_q | drop;

    fifo_cnt = wr_ptr_q - rd_ptr_q;
    wrap_ok  = (wr_ptr_q[AW] == rd_ptr_q[AW]) ? (wr_ptr_q[AW-1:0] >= rd_ptr_q[AW-1:0])
                                              : (wr_ptr_q[AW-1:0] <= rd_ptr_q[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    out_q <= out_d;
    if (fifo_wr && !rst) mem_q[wr_ptr_q[AW-1:0]] <= in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= FULL_OCC);
      assert (wrap_ok);
      assert (occ_q == CW'(fifo_cnt) + CW'(out_vld_q));
      if (drop) assert (wr_ptr_d == wr_ptr_q && rd_ptr_d == rd_ptr_q);
    end
  end

  assign out_r       = out_q;
  assign out_vld_r   = out_vld_q;
  assign stall_r     = stall_q;
  assign occupancy_r = occ_q;
  assign overflow_r  = ovf_q;

endmodule

// File: tb/tb_replay_retire_q.sv
// tb/tb_replay_retire_q.sv - directed vector table plus hand-written sequences for replay_retire_q
module tb_replay_retire_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in = '0;
  logic        in_vld = 1'b0;
  logic        out_accept = 1'b0;
  logic [31:0] out_r;
  logic        out_vld_r;
  logic        stall_r;
  logic [3:0]  occupancy_r;
  logic        overflow_r;

  int n_cmp = 0;
  int n_err = 0;

  replay_retire_q #(.W(32), .DEPTH(8), .SKID(4)) dut (
    .clk(clk), .rst(rst), .in(in), .in_vld(in_vld),
    .out_r(out_r), .out_vld_r(out_vld_r), .out_accept(out_accept),
    .stall_r(stall_r), .occupancy_r(occupancy_r), .overflow_r(overflow_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic        vld;
    logic        acc;
    logic        e_vld;
    logic [31:0] e_out;
    logic [3:0]  e_occ;
    logic        e_stall;
    logic        e_ovf;
  } vec_t;

  task automatic step(input logic r, input logic [31:0] d, input logic v, input logic a);
    @(negedge clk);
    rst = r; in = d; in_vld = v; out_accept = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] eo,
                           input logic [3:0] eocc, input logic es, input logic eov);
    chk({tag, ".out_vld"}, 32'(out_vld_r), 32'(ev));
    if (ev) chk({tag, ".out"}, out_r, eo);
    chk({tag, ".occ"}, 32'(occupancy_r), 32'(eocc));
    chk({tag, ".stall"}, 32'(stall_r), 32'(es));
    chk({tag, ".ovf"}, 32'(overflow_r), 32'(eov));
  endtask

  vec_t vt[$];
  logic [31:0] q[$];

  initial begin
    // rst, din, vld, acc | out_vld, out, occ, stall, ovf (state after the edge)
    vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 32'hA5A5_0001, 1, 1, 1, 32'hA5A5_0001, 1, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 1, 0, 1, 1, 1, 0, 0});
    vt.push_back('{0, 2, 1, 0, 1, 1, 2, 0, 0});
    vt.push_back('{0, 3, 1, 0, 1, 1, 3, 0, 0});
    vt.push_back('{0, 4, 1, 0, 1, 1, 4, 0, 0});
    vt.push_back('{0, 5, 1, 0, 1, 1, 5, 1, 0});
    vt.push_back('{0, 6, 1, 0, 1, 1, 6, 1, 0});
    vt.push_back('{0, 7, 1, 0, 1, 1, 7, 1, 0});
    vt.push_back('{0, 8, 1, 0, 1, 1, 8, 1, 0});
    vt.push_back('{0, 9, 1, 0, 1, 1, 9, 1, 0});
    vt.push_back('{0, 32'hDEAD, 1, 0, 1, 1, 9, 1, 1});
    vt.push_back('{0, 0, 0, 1, 1, 2, 8, 1, 1});
    vt.push_back('{0, 0, 0, 1, 1, 3, 7, 1, 1});
    vt.push_back('{0, 0, 0, 1, 1, 4, 6, 1, 1});
    vt.push_back('{0, 0, 0, 1, 1, 5, 5, 1, 1});
    vt.push_back('{0, 0, 0, 1, 1, 6, 4, 0, 1});
    vt.push_back('{0, 0, 0, 1, 1, 7, 3, 0, 1});
    vt.push_back('{0, 0, 0, 1, 1, 8, 2, 0, 1});
    vt.push_back('{0, 0, 0, 1, 1, 9, 1, 0, 1});
    vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].din, vt[i].vld, vt[i].acc);
      chk_state($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_out, vt[i].e_occ,
                vt[i].e_stall, vt[i].e_ovf);
    end

    // Streaming at one beat per cycle with bypass latency
    for (int i = 0; i < 100; i++) begin
      step(0, 32'(i), 1, 1);
      chk_state($sformatf("stream%0d", i), 1, 32'(i), 1, 0, 0);
    end
    step(0, 0, 0, 1);
    chk_state("stream_end", 0, 0, 0, 0, 0);

    // Fill to capacity, then push and pop together at full capacity
    q.delete();
    for (int i = 0; i < 9; i++) begin
      step(0, 32'(100 + i), 1, 0);
      q.push_back(32'(100 + i));
    end
    chk_state("full", 1, 100, 9, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 32'(200 + k), 1, 1);
      void'(q.pop_front());
      q.push_back(32'(200 + k));
      chk_state($sformatf("pushpop%0d", k), 1, q[0], 9, 1, 0);
    end
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 1);
      void'(q.pop_front());
      if (q.size() > 0)
        chk_state($sformatf("drain%0d", k), 1, q[0], 4'(q.size()), q.size() >= 5, 0);
      else
        chk_state($sformatf("drain%0d", k), 0, 0, 0, 0, 0);
    end

    // Reset in the middle of a backed-up queue
    for (int i = 0; i < 6; i++) step(0, 32'(300 + i), 1, 0);
    chk_state("pre_rst", 1, 300, 6, 1, 0);
    step(1, 32'h77, 1, 0);
    chk_state("mid_rst", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk_state("post_rst", 0, 0, 0, 0, 0);
    step(0, 32'h55, 1, 1);
    chk_state("post_rst_beat", 1, 32'h55, 1, 0, 0);
    step(0, 0, 0, 1);
    chk_state("post_rst_idle", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/replay_retire_q.md
Name: replay_retire_q

Overview:
- Retire queue directly downstream of the replay micro-code pipeline.
- The pipeline's final stage cannot be stalled, so this block accepts one beat per cycle with no accept signal, buffers it, and drains to the consumer over a valid/accept handshake.
- It returns a registered back-pressure request to the pipeline. The request is sized so that beats already in flight when back-pressure asserts never overflow the queue.

Parameters:
- W, 32, payload width in bits.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- SKID, 4, maximum beats that may still arrive after stall_r asserts (pipeline in-flight depth plus 1); 1 <= SKID <= DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in  in  W  retired payload from pipeline output stage.
- in_vld  in  1  payload valid; cannot be refused.
- out_r  out  W  registered payload to consumer.
- out_vld_r  out  1  registered valid to consumer.
- out_accept  in  1  consumer accepts out_r this cycle when out_vld_r=1.
- stall_r  out  1  registered back-pressure to pipeline stall request.
- occupancy_r  out  $clog2(DEPTH+2)  entries held (FIFO plus output register).
- overflow_r  out  1  sticky error; a beat was lost.

Behaviour:
- Only one clock is used. Reset is synchronous and active-high; all state is updated on posedge clk.
- Reset values: out_vld_r=0, stall_r=0, occupancy_r=0, overflow_r=0, FIFO pointers=0. out_r is not reset.
- Storage:
  - FIFO of DEPTH entries plus the output register; total capacity DEPTH+1.
  - FIFO pointers carry one wrap bit. Full means p equal and wrap bits differ; empty means pointers equal.
- Pop:
  - pop = out_vld_r & out_accept.
  - On pop, the output register refills from the FIFO head if the FIFO is non-empty, otherwise from in when in_vld=1, otherwise out_vld_r goes to 0.
- Bypass:
  - When the FIFO is empty and the output register is empty or popping, an arriving beat loads out_r directly. Latency in->out_vld_r is 1 cycle.
  - Otherwise the beat is written to the FIFO tail.
- Ordering: strict FIFO; no reordering or duplication.
- Occupancy:
  - occupancy_w = occupancy_r + in_vld - pop.
  - The counter is always updated, and is asserted equal to the FIFO count plus out_vld_r.
- Back-pressure:
  - stall_r <= (occupancy_w >= DEPTH+1-SKID).
  - stall_r deasserts the cycle after occupancy_w drops below the threshold.
  - There is no hysteresis.
- Overflow:
  - Set when in_vld=1, occupancy_r=DEPTH+1 and pop=0. The beat is dropped and no state changes except overflow_r.
  - overflow_r is cleared only by rst.
- Simultaneous in_vld and pop at full capacity: legal, no overflow. The head moves to the output register and the new beat is written to the tail.
- Simultaneous in_vld and pop with FIFO empty: the new beat replaces the output register directly.
- out_vld_r may not drop without a pop. out_r must be stable while out_vld_r=1 and out_accept=0.
- rst asserted mid-operation discards all contents on the next edge. in_vld during the rst cycle is ignored.
- Assertions:
  - occupancy_r <= DEPTH+1.
  - No pointer movement on an overflow-drop cycle.
  - The 2-bit {wr,rd} wrap-bit relationship is consistent with the count.

Test Plan:
- Reset then single beat: in=0xA5A5_0001 with in_vld for 1 cycle, out_accept=1 -> out_vld_r=1 with out_r=0xA5A5_0001 next cycle, occupancy_r back to 0 a cycle later, stall_r never asserts.
- Streaming: 100 back-to-back beats 0..99 with out_accept held 1 -> out_r emits 0..99 in order, one per cycle at 1-cycle latency, occupancy_r<=1, stall_r=0 throughout.
- Fill to threshold: out_accept=0, beats 1..5 (DEPTH=8, SKID=4) -> stall_r rises the cycle after the 5th beat. A further 4 in-flight beats raise occupancy_r to 9 with overflow_r=0.
- Overflow: from occupancy 9 with out_accept=0, one more beat 0xDEAD -> overflow_r=1, occupancy_r stays 9, and the drain yields the first 9 beats only.
- Full with simultaneous push/pop: occupancy 9, out_accept=1 and in_vld=1 for 10 cycles -> occupancy_r stays 9, no overflow, order preserved. stall_r drops after in_vld stops and occupancy falls below 5.
- Mid-operation reset: occupancy 6 with stall_r=1, assert rst for 1 cycle with in_vld=1 -> all outputs at reset values next cycle. The rst-cycle beat never appears on out_r.
